// File: rtl/ripl_stream_decim_buf_if.sv
// Stream port bundle shared by the decimating buffer and its neighbours.
// Handshake: a token moves In1 when In1_SEND & In1_ACK, and leaves Out1 when Out1_SEND (which already includes Out1_RDY).
interface ripl_stream_decim_buf_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] In1_DATA;
  logic              In1_SEND;
  logic [15:0]       In1_COUNT;
  logic              In1_ACK;
  logic [DATA_W-1:0] Out1_DATA;
  logic              Out1_SEND;
  logic [15:0]       Out1_COUNT;
  logic              Out1_RDY;
  logic              Out1_ACK;

  modport slave (
    input  In1_DATA, In1_SEND, In1_COUNT, Out1_RDY, Out1_ACK,
    output In1_ACK, Out1_DATA, Out1_SEND, Out1_COUNT
  );

  modport master (
    output In1_DATA, In1_SEND, In1_COUNT, Out1_RDY, Out1_ACK,
    input  In1_ACK, Out1_DATA, Out1_SEND, Out1_COUNT
  );
endinterface

// File: rtl/ripl_stream_decim_buf.sv
// Keeps one in every DECIM accepted tokens and buffers the kept ones in a DEPTH-entry FIFO.
// Optional macro RIPL_DECIM_SYNC_EN adds a Sync input that realigns the keep phase.
module ripl_stream_decim_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int DECIM  = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
`ifdef RIPL_DECIM_SYNC_EN
  input  logic                     Sync,
`endif
  ripl_stream_decim_buf_if.slave   bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              tokens_out
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [15:0] PHASE_LAST = 16'(DECIM - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              full;
  logic              empty;
  logic              keep;
  logic              push;
  logic              pop;
  logic [15:0]       phase;
  logic [15:0]       phase_inc;
  logic [15:0]       phase_d;
  logic [31:0]       tokens_q;
  logic              unused_inputs;

  assign unused_inputs = ^{bus.In1_COUNT, bus.Out1_ACK};

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Full blocks the input even if the head pops this cycle: no write-through.
  assign bus.In1_ACK    = bus.In1_SEND & ~full & ~RESET;
  assign bus.Out1_SEND  = ~empty & bus.Out1_RDY & ~RESET;
  assign bus.Out1_COUNT = {15'd0, bus.Out1_SEND};
  assign bus.Out1_DATA  = mem[rd_ptr[AW-1:0]];

  assign keep      = (phase == 16'd0);
  assign push      = bus.In1_ACK & keep;
  assign pop       = bus.Out1_SEND;
  assign phase_inc = (phase == PHASE_LAST) ? 16'd0 : phase + 16'd1;

  always_comb begin
    phase_d = phase;
    if (bus.In1_ACK) phase_d = phase_inc;
`ifdef RIPL_DECIM_SYNC_EN
    // A token arriving with Sync is judged by the old phase; alignment restarts after it.
    if (Sync) phase_d = (bus.In1_ACK && keep) ? phase_inc : 16'd0;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      phase    <= 16'd0;
      tokens_q <= 32'd0;
    end else begin
      phase <= phase_d;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        tokens_q <= tokens_q + 32'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.In1_DATA;
  end

  assign level      = wr_ptr - rd_ptr;
  assign tokens_out = tokens_q;
endmodule

// File: tb/tb_ripl_stream_decim_buf.sv
// Directed bench for ripl_stream_decim_buf: pass-through, decimation, full stall, reset, counter wrap.
// Three instances share stimulus; sel picks which one is driven and observed.
module tb_ripl_stream_decim_buf;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  = 1'b1;
  logic        send = 1'b0;
  logic [15:0] data = 16'd0;
  logic        rdy  = 1'b0;
  logic        sync = 1'b0;
  logic [1:0]  sel  = 2'd0;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  logic        got_ack;
  logic        got_osend;
  logic [15:0] got_odata;
  logic [15:0] got_ocount;
  logic [31:0] got_tok;
  logic [31:0] got_level;

  logic [2:0]  lvl1, lvl3, lvl4;
  logic [31:0] tok1, tok3, tok4;

  ripl_stream_decim_buf_if #(.DATA_W(16)) b1();
  ripl_stream_decim_buf_if #(.DATA_W(16)) b3();
  ripl_stream_decim_buf_if #(.DATA_W(16)) b4();

  assign b1.In1_DATA  = data;
  assign b1.In1_SEND  = send && (sel == 2'd0);
  assign b1.In1_COUNT = 16'd0;
  assign b1.Out1_RDY  = rdy && (sel == 2'd0);
  assign b1.Out1_ACK  = 1'b0;
  assign b3.In1_DATA  = data;
  assign b3.In1_SEND  = send && (sel == 2'd1);
  assign b3.In1_COUNT = 16'd0;
  assign b3.Out1_RDY  = rdy && (sel == 2'd1);
  assign b3.Out1_ACK  = 1'b0;
  assign b4.In1_DATA  = data;
  assign b4.In1_SEND  = send && (sel == 2'd2);
  assign b4.In1_COUNT = 16'd0;
  assign b4.Out1_RDY  = rdy && (sel == 2'd2);
  assign b4.Out1_ACK  = 1'b0;

  ripl_stream_decim_buf #(.DATA_W(16), .DEPTH(4), .DECIM(1)) u_d1 (
    .CLK(clk), .RESET(rst),
`ifdef RIPL_DECIM_SYNC_EN
    .Sync(1'b0),
`endif
    .bus(b1.slave), .level(lvl1), .tokens_out(tok1)
  );

  ripl_stream_decim_buf #(.DATA_W(16), .DEPTH(4), .DECIM(3)) u_d3 (
    .CLK(clk), .RESET(rst),
`ifdef RIPL_DECIM_SYNC_EN
    .Sync(1'b0),
`endif
    .bus(b3.slave), .level(lvl3), .tokens_out(tok3)
  );

  ripl_stream_decim_buf #(.DATA_W(16), .DEPTH(4), .DECIM(4)) u_d4 (
    .CLK(clk), .RESET(rst),
`ifdef RIPL_DECIM_SYNC_EN
    .Sync(sync && (sel == 2'd2)),
`endif
    .bus(b4.slave), .level(lvl4), .tokens_out(tok4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sample();
    if (sel == 2'd0) begin
      got_ack = b1.In1_ACK; got_osend = b1.Out1_SEND; got_odata = b1.Out1_DATA;
      got_ocount = b1.Out1_COUNT; got_tok = tok1; got_level = 32'(lvl1);
    end else if (sel == 2'd1) begin
      got_ack = b3.In1_ACK; got_osend = b3.Out1_SEND; got_odata = b3.Out1_DATA;
      got_ocount = b3.Out1_COUNT; got_tok = tok3; got_level = 32'(lvl3);
    end else begin
      got_ack = b4.In1_ACK; got_osend = b4.Out1_SEND; got_odata = b4.Out1_DATA;
      got_ocount = b4.Out1_COUNT; got_tok = tok4; got_level = 32'(lvl4);
    end
  endtask

  // One clock: drive at the falling edge, sample just after, score any emitted token.
  task automatic cycle(input logic s, input logic [15:0] d, input logic r);
    @(negedge clk);
    send = s; data = d; rdy = r;
    #1;
    sample();
    if (got_osend) begin
      check("out_count", 32'(got_ocount), 32'd1);
      if (exp_q.size() > 0) check("out_data", 32'(got_odata), 32'(exp_q.pop_front()));
      else check("out_extra", 32'(got_osend), 32'd0);
    end
  endtask

  task automatic do_reset(input logic s);
    @(negedge clk);
    rst = 1'b1; send = s; data = 16'hDEAD; rdy = 1'b1;
    #1;
    sample();
    check("rst_ack", 32'(got_ack), 32'd0);
    check("rst_osend", 32'(got_osend), 32'd0);
    @(negedge clk);
    rst = 1'b0; send = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pass-through, DECIM=1
    sel = 2'd0;
    do_reset(1'b0);
    cycle(1'b0, 16'd0, 1'b1);
    check("reset_level", got_level, 32'd0);
    check("reset_tok", got_tok, 32'd0);
    check("reset_osend", 32'(got_osend), 32'd0);
    check("reset_count", 32'(got_ocount), 32'd0);
    for (int i = 1; i <= 8; i++) exp_q.push_back(16'(i));
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 16'(i), 1'b1);
      check("t1_ack", 32'(got_ack), 32'd1);
      check("t1_latency", 32'(got_osend), 32'(i > 1));
    end
    cycle(1'b0, 16'd0, 1'b1);
    cycle(1'b0, 16'd0, 1'b1);
    check("t1_left", 32'(exp_q.size()), 32'd0);
    check("t1_tok", got_tok, 32'd8);
    check("t1_level", got_level, 32'd0);

    // Decimate by 3
    sel = 2'd1;
    exp_q.push_back(16'h10); exp_q.push_back(16'h13); exp_q.push_back(16'h16);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 16'(16'h10 + i), 1'b1);
      check("t2_ack", 32'(got_ack), 32'd1);
    end
    cycle(1'b0, 16'd0, 1'b1);
    cycle(1'b0, 16'd0, 1'b1);
    check("t2_left", 32'(exp_q.size()), 32'd0);
    check("t2_tok", got_tok, 32'd3);

    // Mid-stream reset on the DECIM=3 instance, phase left at 2
    exp_q.push_back(16'h30); exp_q.push_back(16'h33);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 16'(16'h30 + i), 1'b0);
      check("t4_ack", 32'(got_ack), 32'd1);
    end
    cycle(1'b0, 16'd0, 1'b0);
    check("t4_level_pre", got_level, 32'd2);
    check("t4_tok_pre", got_tok, 32'd3);
    do_reset(1'b1);
    cycle(1'b0, 16'd0, 1'b1);
    check("t4_level", got_level, 32'd0);
    check("t4_tok", got_tok, 32'd0);
    check("t4_osend", 32'(got_osend), 32'd0);
    check("t4_count", 32'(got_ocount), 32'd0);
    exp_q.push_back(16'h40);
    cycle(1'b1, 16'h40, 1'b1);
    check("t4_ack_after", 32'(got_ack), 32'd1);
    cycle(1'b0, 16'd0, 1'b1);
    check("t4_emit", 32'(got_osend), 32'd1);
    cycle(1'b0, 16'd0, 1'b1);
    check("t4_left", 32'(exp_q.size()), 32'd0);
    check("t4_tok_after", got_tok, 32'd1);

    // Full stall with DEPTH=4
    sel = 2'd0;
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(16'h20 + i));
    for (int n = 0; n < 6; n++) begin
      cycle(1'b1, 16'(16'h20 + ((n < 4) ? n : 4)), 1'b0);
      check("t3_fill_ack", 32'(got_ack), 32'(n < 4));
    end
    check("t3_level_full", got_level, 32'd4);
    exp_q.push_back(16'h24); exp_q.push_back(16'h25); exp_q.push_back(16'h26);
    cycle(1'b1, 16'h24, 1'b1);
    check("t3_first_pop_ack", 32'(got_ack), 32'd0);
    check("t3_first_pop_send", 32'(got_osend), 32'd1);
    cycle(1'b1, 16'h24, 1'b1);
    check("t3_resume_ack", 32'(got_ack), 32'd1);
    cycle(1'b1, 16'h25, 1'b1);
    check("t3_ack2", 32'(got_ack), 32'd1);
    cycle(1'b1, 16'h26, 1'b1);
    check("t3_ack3", 32'(got_ack), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'd0, 1'b1);
    check("t3_left", 32'(exp_q.size()), 32'd0);
    check("t3_level_end", got_level, 32'd0);

    // tokens_out wrap
    @(posedge clk);
    #2;
    force u_d1.tokens_q = 32'hFFFF_FFFE;
    #1;
    release u_d1.tokens_q;
    exp_q.push_back(16'h50); exp_q.push_back(16'h51); exp_q.push_back(16'h52);
    cycle(1'b1, 16'h50, 1'b1);
    check("t5_tok0", got_tok, 32'hFFFF_FFFE);
    cycle(1'b1, 16'h51, 1'b1);
    cycle(1'b1, 16'h52, 1'b1);
    check("t5_tok1", got_tok, 32'hFFFF_FFFF);
    cycle(1'b0, 16'd0, 1'b1);
    check("t5_tok2", got_tok, 32'h0000_0000);
    cycle(1'b0, 16'd0, 1'b1);
    check("t5_tok3", got_tok, 32'h0000_0001);
    check("t5_left", 32'(exp_q.size()), 32'd0);

`ifdef RIPL_DECIM_SYNC_EN
    // Sync realigns the DECIM=4 phase
    sel = 2'd2;
    do_reset(1'b0);
    exp_q.push_back(16'h90); exp_q.push_back(16'hA0);
    cycle(1'b1, 16'h90, 1'b1);
    cycle(1'b1, 16'h91, 1'b1);
    @(negedge clk);
    send = 1'b0; sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    cycle(1'b1, 16'hA0, 1'b1);
    check("t6_ack", 32'(got_ack), 32'd1);
    cycle(1'b0, 16'd0, 1'b1);
    cycle(1'b0, 16'd0, 1'b1);
    check("t6_left", 32'(exp_q.size()), 32'd0);
    check("t6_tok", got_tok, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
